// File: rtl/score_display_ctrl.sv
// Score/best-score controller for a six-digit 7-seg display.
// Ports: clk, rst_n, start/point_inc/crash pulses; digit0-5, state, new_best.
module score_display_ctrl #(
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       point_inc,
  input  logic       crash,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit4,
  output logic [3:0] digit5,
  output logic [1:0] state,
  output logic       new_best
);

  localparam int CW = $clog2(BLINK_HALF);
  localparam logic [CW-1:0] CMAX = CW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } st_t;

  st_t st_q, st_d;
  logic [11:0] score_q, score_d;
  logic [11:0] best_q, best_d;
  logic [11:0] inc, sc_next;
  logic nb_q, nb_d;
  logic ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // BCD +1 with ripple carry, saturating at 999
  always_comb begin
    inc = score_q;
    if (score_q != 12'h999) begin
      if (score_q[3:0] != 4'd9) begin
        inc[3:0] = score_q[3:0] + 4'd1;
      end else begin
        inc[3:0] = 4'd0;
        if (score_q[7:4] != 4'd9) begin
          inc[7:4] = score_q[7:4] + 4'd1;
        end else begin
          inc[7:4]  = 4'd0;
          inc[11:8] = score_q[11:8] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    score_d = score_q;
    best_d  = best_q;
    nb_d    = nb_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    sc_next = point_inc ? inc : score_q;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          st_d    = PLAY;
          score_d = 12'h000;
          nb_d    = 1'b0;
        end
      end
      PLAY: begin
        score_d = sc_next;
        if (crash) begin
          st_d  = OVER;
          cnt_d = '0;
          ph_d  = 1'b0;
          // BCD digits order like binary, so a packed
          // compare is the hundreds-first digit compare
          if (sc_next > best_q) begin
            best_d = sc_next;
            nb_d   = 1'b1;
          end
        end
      end
      OVER: begin
        if (start) begin
          st_d    = PLAY;
          score_d = 12'h000;
          nb_d    = 1'b0;
          cnt_d   = '0;
          ph_d    = 1'b0;
        end else if (cnt_q == CMAX) begin
          cnt_d = '0;
          ph_d  = ~ph_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      score_q <= 12'h000;
      best_q  <= 12'h000;
      nb_q    <= 1'b0;
      ph_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      score_q <= score_d;
      best_q  <= best_d;
      nb_q    <= nb_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
    end
  end

  function automatic logic [11:0] lz(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[11:8] == 4'd0) r[11:8] = 4'hF;
    if (v[11:4] == 8'd0) r[7:4] = 4'hF;
    return r;
  endfunction

  logic [11:0] sd, bd;

  always_comb begin
    sd = lz(score_q);
    bd = lz(best_q);
    if (st_q == OVER && ph_q) sd = 12'hFFF;
  end

  assign digit0   = sd[3:0];
  assign digit1   = sd[7:4];
  assign digit2   = sd[11:8];
  assign digit3   = bd[3:0];
  assign digit4   = bd[7:4];
  assign digit5   = bd[11:8];
  assign state    = st_q;
  assign new_best = nb_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl.
// Uses BLINK_HALF=4; checks digits, state and new_best.
module tb_score_display_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic point_inc = 1'b0;
  logic crash = 1'b0;
  logic [3:0] digit0, digit1, digit2;
  logic [3:0] digit3, digit4, digit5;
  logic [1:0] state;
  logic new_best;
  logic [23:0] disp;

  int checks = 0;
  int failures = 0;

  score_display_ctrl #(.BLINK_HALF(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .point_inc(point_inc),
    .crash(crash),
    .digit0(digit0),
    .digit1(digit1),
    .digit2(digit2),
    .digit3(digit3),
    .digit4(digit4),
    .digit5(digit5),
    .state(state),
    .new_best(new_best)
  );

  assign disp = {digit5, digit4, digit3,
                 digit2, digit1, digit0};

  always #5 clk = ~clk;

  task automatic pulse(input logic s, input logic p,
                       input logic c);
    @(negedge clk);
    start = s;
    point_inc = p;
    crash = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    point_inc = 1'b0;
    crash = 1'b0;
  endtask

  task automatic points(input int n);
    for (int i = 0; i < n; i++) pulse(1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (state !== 2'b00) begin
      failures++;
      $display("FAIL reset_state got=%b exp=00", state);
    end
    checks++;
    if (disp !== 24'hFF0FF0) begin
      failures++;
      $display("FAIL reset_digits got=%h exp=ff0ff0", disp);
    end
    checks++;
    if (new_best !== 1'b0) begin
      failures++;
      $display("FAIL reset_new_best got=%b exp=0", new_best);
    end
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_counting;
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (state !== 2'b01) begin
      failures++;
      $display("FAIL start_state got=%b exp=01", state);
    end
    points(12);
    checks++;
    if (disp !== 24'hFF0F12) begin
      failures++;
      $display("FAIL count12 got=%h exp=ff0f12", disp);
    end
    points(88);
    checks++;
    if (disp[11:0] !== 12'h100) begin
      failures++;
      $display("FAIL count100 got=%h exp=100", disp[11:0]);
    end
  endtask

  task automatic test_saturation;
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    points(1005);
    checks++;
    if (disp[11:0] !== 12'h999) begin
      failures++;
      $display("FAIL saturate got=%h exp=999", disp[11:0]);
    end
  endtask

  task automatic test_crash_blink;
    logic [11:0] exp;
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    points(12);
    pulse(1'b0, 1'b0, 1'b1);
    checks++;
    if (state !== 2'b10) begin
      failures++;
      $display("FAIL crash_state got=%b exp=10", state);
    end
    checks++;
    if (disp[23:12] !== 12'hF12) begin
      failures++;
      $display("FAIL crash_best got=%h exp=f12", disp[23:12]);
    end
    checks++;
    if (new_best !== 1'b1) begin
      failures++;
      $display("FAIL crash_new_best got=%b exp=1", new_best);
    end
    for (int k = 0; k < 12; k++) begin
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      exp = (((k / 4) % 2) == 0) ? 12'hF12 : 12'hFFF;
      checks++;
      if (disp !== {12'hF12, exp}) begin
        failures++;
        $display("FAIL blink k=%0d got=%h exp=f12%h",
                 k, disp, exp);
      end
    end
    pulse(1'b1, 1'b0, 1'b0);
    checks++;
    if (disp !== 24'hF12FF0 || state !== 2'b01) begin
      failures++;
      $display("FAIL restart got=%h/%b exp=f12ff0/01",
               disp, state);
    end
    checks++;
    if (new_best !== 1'b0) begin
      failures++;
      $display("FAIL restart_nb got=%b exp=0", new_best);
    end
  endtask

  task automatic test_no_new_best;
    points(5);
    pulse(1'b0, 1'b0, 1'b1);
    checks++;
    if (disp !== 24'hF12FF5 || state !== 2'b10) begin
      failures++;
      $display("FAIL no_best got=%h/%b exp=f12ff5/10",
               disp, state);
    end
    checks++;
    if (new_best !== 1'b0) begin
      failures++;
      $display("FAIL no_best_nb got=%b exp=0", new_best);
    end
  endtask

  task automatic test_simultaneous;
    pulse(1'b1, 1'b0, 1'b0);
    points(12);
    pulse(1'b0, 1'b1, 1'b1);
    checks++;
    if (disp !== 24'hF13F13 || state !== 2'b10) begin
      failures++;
      $display("FAIL simul got=%h/%b exp=f13f13/10",
               disp, state);
    end
    checks++;
    if (new_best !== 1'b1) begin
      failures++;
      $display("FAIL simul_nb got=%b exp=1", new_best);
    end
  endtask

  task automatic test_async_reset;
    pulse(1'b1, 1'b0, 1'b0);
    points(7);
    checks++;
    if (disp !== 24'hF13FF7) begin
      failures++;
      $display("FAIL pre_rst got=%h exp=f13ff7", disp);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (disp !== 24'hFF0FF0 || state !== 2'b00 ||
        new_best !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got=%h/%b/%b exp=ff0ff0/00/0",
               disp, state, new_best);
    end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_counting();
    test_saturation();
    test_crash_blink();
    test_no_new_best();
    test_simultaneous();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
# score_display_ctrl

Game score and best-score controller for the six-digit seven-segment display. It counts points in BCD during play and latches the best score on crash. It sequences the display through idle, play and game-over states, blinking the score after a crash. It drives six 4-bit digit codes straight into the per-digit seven-segment decoders; code 4'hF renders as a blank digit.

## Interface
- `BLINK_HALF`, default 25_000_000: clock cycles per blink half-period in OVER (0.5 s at 50 MHz). Must be ≥ 2.

- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `start`  in  1  single-cycle pulse: begin a new game
- `point_inc`  in  1  single-cycle pulse: bird cleared a pipe
- `crash`  in  1  single-cycle pulse: bird collided
- `digit0`–`digit2`  out  4 each  score, ones/tens/hundreds; 0–9 or 4'hF blank
- `digit3`–`digit5`  out  4 each  best score, ones/tens/hundreds; 0–9 or 4'hF blank
- `state`  out  2  2'b00 IDLE, 2'b01 PLAY, 2'b10 OVER
- `new_best`  out  1  high in OVER/IDLE when the last game set a new best

## Operation
- Registers:
  - 3-digit BCD `score`, 0–999.
  - 3-digit BCD `best`.
  - state.
  - blink counter, width $clog2(BLINK_HALF).
  - blink phase bit.
  - `new_best`.
- IDLE:
  - Shows the last `score` and `best` steadily.
  - `start` → PLAY; `score` ← 0 and `new_best` ← 0 on the same edge.
  - `point_inc` and `crash` are ignored.
- PLAY:
  - `point_inc` adds 1 to `score` in BCD with ripple carry (9→0 carries to the next digit).
  - At 999, `score` saturates and does not wrap.
  - `crash` → OVER. If the post-increment score is greater than `best`, then `best` ← that score and `new_best` ← 1.
  - The best-score comparison is numeric, done digit by digit from the hundreds digit down.
  - `start` is ignored.
- Simultaneous `point_inc` and `crash` in PLAY: the increment is applied first. The incremented score is both the stored score and the value compared against `best`.
- OVER:
  - Blink counter and phase are cleared on entry; phase starts at visible.
  - The counter counts 0..BLINK_HALF−1 and toggles phase on wrap.
  - While phase is blank, `digit0`–`digit2` = 4'hF. Best digits never blink.
  - `start` → PLAY: `score` ← 0 and `new_best` ← 0; the blink counter is held cleared.
  - `point_inc` and `crash` are ignored.
  - There is no OVER→IDLE transition; IDLE is reached only through reset.
- Leading-zero blanking, applied separately to the score group and the best group:
  - The hundreds digit is blank if it is 0.
  - The tens digit is blank if both hundreds and tens are 0.
  - The ones digit is always shown.
  - Blink blanking overrides this in the blank phase.
- Input pulses held high for several cycles act once per cycle; upstream logic must deliver single-cycle pulses.

## Timing
- Reset values, asserted immediately and asynchronously:
  - `state` = 2'b00.
  - `score` = `best` = 0; `new_best` = 0.
  - Blink counter and phase are cleared.
  - Digits {5..0} = F,F,0,F,F,0.
- Reset asserted mid-game discards `score`, `best` and the blink state with no clock required. Reset release is synchronised by the system reset bridge.
- Outputs are combinational decodes of registered state. They reflect an input event on the rising edge that samples it, with zero additional cycles of latency.
- A `crash` sampled at edge N gives `state` = OVER and the updated `best`/`new_best` after edge N.
- Blink, with edge N as the OVER-entry edge:
  - Score visible for edges N..N+BLINK_HALF−1.
  - Score blank for the next BLINK_HALF edges.
  - Then repeat.

## Test plan
- **Reset:** hold `rst_n`=0 with no clock → `state`=00, digits {5..0}=F,F,0,F,F,0, `new_best`=0.
- **BCD counting:**
  - `start`, then 12 `point_inc` → digits {2..0}=F,1,2.
  - Continue to 100 total → digits {2..0}=1,0,0, confirming a double carry on the same edge.
- **Saturation:** 1005 `point_inc` in PLAY → score 999; digits {2..0}=9,9,9.
- **Crash and blink**, with BLINK_HALF=4:
  - Score 12, best 0, `crash` → `state`=10, best digits F,1,2, `new_best`=1.
  - Score digits visible for 4 cycles, then F,F,F for 4 cycles, then visible again.
  - `start` → score F,F,0, `new_best`=0, best still 12.
- **No new best:** second game scores 5, then `crash` → best stays 12, `new_best`=0.
- **Simultaneous events:**
  - Best 12, score 12, `point_inc` and `crash` on the same cycle → score 13, best 13, `new_best`=1.
  - Separately, assert `rst_n`=0 mid-PLAY → all outputs reach reset values before the next clock edge.
